l2_bus_responder: RTL and testbench

- Responder (slave) end of the Wishbone-style L2 bus (cyc/stb/we/sel/adr/dat, ack/err) that the cache interconnect drives.
- Accepts one request at a time, converts it into a single read or write on the physical-memory port, and returns a one-cycle ack with read data.
- Adds a mandatory one-cycle quiet gap after each ack so the upstream arbiter can switch masters.
- Has an optional response timeout that completes the bus cycle with err instead of ack.

---
 rtl/l2_bus_pkg.sv | 17 +
 rtl/l2_resp_timer.sv | 39 +++
 rtl/l2_bus_responder.sv | 146 ++++++++++++++
 tb/tb_l2_bus_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_bus_pkg.sv
// Shared definitions for the L2 bus responder and its timer.
package l2_bus_pkg;

  localparam int L2_ADDR_W  = 16;
  localparam int L2_DATA_W  = 128;
  localparam int L2_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ACK   = 3'd2,
    ST_ERR   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_GAP   = 3'd5
  } l2_state_e;

endpackage

// File: rtl/l2_resp_timer.sv
// Saturating response timer: counts enabled cycles since the last clear and
// flags expiry once LIMIT cycles have been spent. LIMIT=0 disables it.
module l2_resp_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  generate
    if (LIMIT == 0) begin : g_off
      assign o_expired = 1'b0;
    end else begin : g_on
      localparam int CNT_W = $clog2(LIMIT + 1);
      localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LIMIT - 1);
      localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(LIMIT);

      logic [CNT_W-1:0] r_cnt;

      // Count up while enabled, holding at LIMIT so expiry stays asserted.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (i_clear) begin
          r_cnt <= '0;
        end else if (i_enable && (r_cnt != C_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      // The cycle holding LIMIT-1 is the last one allowed to wait.
      assign o_expired = (r_cnt >= C_LAST);
    end
  endgenerate

endmodule

// File: rtl/l2_bus_responder.sv
// Responder end of the L2 bus: one request at a time, turned into a single
// memory read or write, completed by a one-cycle ack (or err on timeout) and
// followed by a one-cycle quiet gap.
//
// state | meaning
// IDLE  | waiting for cyc & stb
// REQ   | memory request active, bus master still attached
// ACK   | one-cycle ack pulse
// ERR   | one-cycle err pulse (memory never answered)
// DRAIN | master aborted; finish the memory access silently
// GAP   | quiet cycle for the upstream arbiter
module l2_bus_responder
  import l2_bus_pkg::*;
#(
  parameter int ADDR_W  = L2_ADDR_W,
  parameter int DATA_W  = L2_DATA_W,
  parameter int TIMEOUT = L2_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                l2_cyc,
  input  logic                l2_stb,
  input  logic                l2_we,
  input  logic [ADDR_W-1:0]   l2_adr,
  input  logic [DATA_W/8-1:0] l2_sel,
  input  logic [DATA_W-1:0]   l2_wdata,
  output logic [DATA_W-1:0]   l2_rdata,
  output logic                l2_ack,
  output logic                l2_err,
  output logic                busy,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_byte_en,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  l2_state_e           r_state;
  l2_state_e           w_next_state;
  logic                w_accept;
  logic                w_capture;
  logic                w_mem_active;
  logic                w_expired;

  logic [ADDR_W-1:0]   r_adr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_sel;
  logic                r_we;
  logic [DATA_W-1:0]   r_rdata;

  assign w_mem_active = (r_state == ST_REQ) || (r_state == ST_DRAIN);

  l2_resp_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (r_state == ST_IDLE),
    .i_enable  (w_mem_active),
    .o_expired (w_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; mem_resp outranks both abort-less timeout and expiry.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (l2_cyc && l2_stb) begin
          w_accept     = 1'b1;
          w_next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_resp) begin
          if (!l2_cyc) begin
            w_next_state = ST_GAP;
          end else begin
            w_capture    = ~r_we;
            w_next_state = ST_ACK;
          end
        end else if (!l2_cyc) begin
          w_next_state = ST_DRAIN;
        end else if (w_expired) begin
          w_next_state = ST_ERR;
        end
      end
      ST_DRAIN: begin
        if (mem_resp || w_expired) begin
          w_next_state = ST_GAP;
        end
      end
      ST_ACK:  w_next_state = ST_GAP;
      ST_ERR:  w_next_state = ST_GAP;
      ST_GAP:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request registers: frozen for the whole memory access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr   <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
    end else if (w_accept) begin
      r_adr   <= l2_adr;
      r_wdata <= l2_wdata;
      r_sel   <= l2_sel;
      r_we    <= l2_we;
    end
  end

  // Read data holds until the next completed read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_capture) begin
      r_rdata <= mem_rdata;
    end
  end

  assign l2_rdata    = r_rdata;
  assign l2_ack      = (r_state == ST_ACK);
  assign l2_err      = (r_state == ST_ERR);
  assign busy        = (r_state != ST_IDLE);
  assign mem_read    = w_mem_active & ~r_we;
  assign mem_write   = w_mem_active & r_we;
  assign mem_address = r_adr;
  assign mem_wdata   = r_wdata;
  assign mem_byte_en = r_sel;

endmodule

// File: tb/tb_l2_bus_responder.sv
// Directed bench for l2_bus_responder with a response scoreboard.
module tb_l2_bus_responder;

  localparam int AW = 16;
  localparam int DW = 128;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          l2_cyc, l2_stb, l2_we;
  logic [AW-1:0] l2_adr;
  logic [SW-1:0] l2_sel;
  logic [DW-1:0] l2_wdata, l2_rdata;
  logic          l2_ack, l2_err, busy, mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_byte_en;
  logic          mem_resp;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  l2_bus_responder #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we),
    .l2_adr(l2_adr), .l2_sel(l2_sel), .l2_wdata(l2_wdata), .l2_rdata(l2_rdata),
    .l2_ack(l2_ack), .l2_err(l2_err), .busy(busy), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_byte_en(mem_byte_en), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic          is_err;
    logic [DW-1:0] rdata;
    int            cycle;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  int   rd_hi  = 0;
  int   wr_hi  = 0;
  logic prev_ack = 1'b0;

  localparam logic [DW-1:0] R1 = {16{8'hA5}};
  localparam logic [DW-1:0] WD = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [DW-1:0] R2 = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
  localparam logic [DW-1:0] R3 = 128'hDEAD_BEEF_CAFE_F00D_1111_2222_3333_4444;
  localparam logic [DW-1:0] R4 = 128'h5555_AAAA_5555_AAAA_0F0F_F0F0_3C3C_C3C3;
  localparam logic [DW-1:0] RX = {16{8'h77}};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, then score any completion.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    if (mem_read)  rd_hi++;
    if (mem_write) wr_hi++;
    if (l2_ack || l2_err) begin
      chk("ack_err_excl", l2_ack & l2_err, 0);
      if (l2_ack) chk("ack_adjacent", prev_ack, 0);
      if (sb.size() == 0) begin
        chk("unexpected_resp", l2_ack | l2_err, 0);
      end else begin
        e = sb.pop_front();
        chk("resp_kind",  l2_err,   e.is_err);
        chk("resp_cycle", cyc_n,    e.cycle);
        chk("resp_rdata", l2_rdata, e.rdata);
      end
    end
    prev_ack = l2_ack;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] adr,
                       input logic [SW-1:0] sel, input logic [DW-1:0] wd);
    l2_cyc = 1'b1; l2_stb = 1'b1; l2_we = we;
    l2_adr = adr;  l2_sel = sel;  l2_wdata = wd;
  endtask

  task automatic idle_bus();
    l2_cyc = 1'b0; l2_stb = 1'b0; mem_resp = 1'b0;
  endtask

  int c0;

  initial begin
    rst_n = 1'b0;
    l2_cyc = 0; l2_stb = 0; l2_we = 0; l2_adr = '0; l2_sel = '0; l2_wdata = '0;
    mem_resp = 0; mem_rdata = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_ack", l2_ack, 0);
    chk("rst_err", l2_err, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_rdata", l2_rdata, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_byte_en", mem_byte_en, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Read, zero-wait
    rd_hi = 0;
    c0 = cyc_n;
    issue(1'b0, 16'h0040, '1, '0);
    sb.push_back('{1'b0, R1, c0 + 2});
    tick();
    chk("rd0_busy", busy, 1);
    chk("rd0_mem_read", mem_read, 1);
    chk("rd0_mem_write", mem_write, 0);
    chk("rd0_addr", mem_address, 16'h0040);
    l2_stb = 1'b0; mem_resp = 1'b1; mem_rdata = R1;
    tick();
    chk("rd0_ack", l2_ack, 1);
    chk("rd0_mem_read_off", mem_read, 0);
    idle_bus();
    tick();
    chk("rd0_gap_busy", busy, 1);
    chk("rd0_gap_ack", l2_ack, 0);
    tick();
    chk("rd0_idle_busy", busy, 0);
    chk("rd0_read_cycles", rd_hi, 1);

    // Write, 3 wait states; bus inputs scrambled mid-request
    wr_hi = 0;
    c0 = cyc_n;
    issue(1'b1, 16'h0ABC, 16'hFFFF, WD);
    sb.push_back('{1'b0, R1, c0 + 5});
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("wr_mem_write", mem_write, 1);
      chk("wr_mem_read", mem_read, 0);
      chk("wr_addr", mem_address, 16'h0ABC);
      chk("wr_wdata", mem_wdata, WD);
      chk("wr_sel", mem_byte_en, 16'hFFFF);
      l2_stb = 1'b0; l2_adr = 16'h9999; l2_wdata = RX; l2_sel = 16'h00F0; l2_we = 1'b0;
      if (k == 4) begin
        mem_resp = 1'b1; mem_rdata = RX;
      end
    end
    tick();
    chk("wr_ack", l2_ack, 1);
    idle_bus();
    tick(); tick();
    chk("wr_write_cycles", wr_hi, 4);

    // Back-to-back reads with stb held
    c0 = cyc_n;
    issue(1'b0, 16'h0100, '1, '0);
    sb.push_back('{1'b0, R2, c0 + 2});
    sb.push_back('{1'b0, R3, c0 + 6});
    tick();
    chk("b2b_first_read", mem_read, 1);
    mem_resp = 1'b1; mem_rdata = R2;
    tick();
    mem_resp = 1'b0; l2_adr = 16'h0200;
    tick();
    chk("b2b_gap_busy", busy, 1);
    chk("b2b_gap_read", mem_read, 0);
    chk("b2b_gap_ack", l2_ack, 0);
    tick();
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_read", mem_read, 0);
    tick();
    chk("b2b_second_read", mem_read, 1);
    chk("b2b_second_addr", mem_address, 16'h0200);
    l2_stb = 1'b0; mem_resp = 1'b1; mem_rdata = R3;
    tick();
    idle_bus();
    tick(); tick();

    // Timeout: memory never answers
    rd_hi = 0;
    c0 = cyc_n;
    issue(1'b0, 16'h0300, '1, '0);
    sb.push_back('{1'b1, R3, c0 + 9});
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("to_mem_read", mem_read, 1);
      l2_stb = 1'b0;
    end
    tick();
    chk("to_err", l2_err, 1);
    chk("to_ack", l2_ack, 0);
    chk("to_read_off", mem_read, 0);
    idle_bus();
    tick(); tick();
    chk("to_read_cycles", rd_hi, 8);
    c0 = cyc_n;
    issue(1'b0, 16'h0310, '1, '0);
    sb.push_back('{1'b0, R4, c0 + 3});
    tick();
    l2_stb = 1'b0;
    tick();
    mem_resp = 1'b1; mem_rdata = R4;
    tick();
    idle_bus();
    tick(); tick();

    // Master abort in the 2nd REQ cycle
    rd_hi = 0;
    issue(1'b0, 16'h0400, '1, '0);
    tick();
    l2_stb = 1'b0;
    tick();
    l2_cyc = 1'b0;
    tick();
    chk("ab_drain_busy", busy, 1);
    chk("ab_drain_read", mem_read, 1);
    tick();
    chk("ab_drain_read2", mem_read, 1);
    tick();
    chk("ab_drain_read3", mem_read, 1);
    mem_resp = 1'b1; mem_rdata = RX;
    tick();
    mem_resp = 1'b0;
    chk("ab_gap_busy", busy, 1);
    chk("ab_gap_read", mem_read, 0);
    tick();
    chk("ab_idle_busy", busy, 0);
    chk("ab_read_cycles", rd_hi, 5);
    chk("ab_rdata_held", l2_rdata, R4);

    // Async reset in the middle of REQ
    issue(1'b0, 16'h0500, '1, '0);
    tick();
    chk("ar_req_read", mem_read, 1);
    l2_stb = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_read_drop", mem_read, 0);
    chk("ar_busy_drop", busy, 0);
    chk("ar_rdata_clr", l2_rdata, 0);
    idle_bus();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    c0 = cyc_n;
    issue(1'b0, 16'h0600, '1, '0);
    sb.push_back('{1'b0, R1, c0 + 2});
    tick();
    chk("ar_post_read", mem_read, 1);
    l2_stb = 1'b0; mem_resp = 1'b1; mem_rdata = R1;
    tick();
    idle_bus();
    tick(); tick();

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
